// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: SLL/SRL/SRA/ROL shifter built from SHW binary 2:1 mux stages, with sticky and zero flags.
// Latency: 1 cycle (PIPE_MID=0) or 2 cycles (PIPE_MID=1) from input handshake to o_out_valid.
// Backpressure: valid/ready; a register loads when empty or draining, so full rate when unstalled.
module barrel_shift_pipe #(
    parameter int WIDTH    = 25,
    parameter int SHW      = 5,
    parameter int PIPE_MID = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_din,
    input  logic [SHW-1:0]   i_amt,
    input  logic [1:0]       i_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_sticky,
    output logic             o_zero
);

    localparam logic [1:0]     MODE_SLL = 2'b00;
    localparam logic [1:0]     MODE_SRL = 2'b01;
    localparam logic [1:0]     MODE_SRA = 2'b10;
    localparam logic [1:0]     MODE_ROL = 2'b11;
    localparam logic [SHW-1:0] W_AMT    = SHW'(WIDTH);

    // Input-side operand preparation
    logic [SHW-1:0]   w_amt_in;
    logic [WIDTH-1:0] w_prep;
    logic             w_sign_in;

    // Signals feeding the fine (<4) stages, either straight through or from the mid register
    logic [WIDTH-1:0] w_coarse_dat;
    logic             w_coarse_st;
    logic [WIDTH-1:0] w_fine_dat;
    logic             w_fine_st;
    logic [SHW-1:0]   w_amt_f;
    logic [1:0]       w_mode_f;
    logic             w_sign_f;
    logic             w_fine_vld;

    // Final stage result
    logic [WIDTH-1:0] w_shifted;
    logic             w_sticky;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_res;

    // Output register
    logic             r_out_vld;
    logic [WIDTH-1:0] r_dout;
    logic             r_sticky;
    logic             r_zero;
    logic             w_out_can;

    // Rotate uses amt mod WIDTH; amt < 2*WIDTH so one conditional subtract is enough
    always_comb begin
        w_amt_in = i_amt;
        if ((i_mode == MODE_ROL) && (i_amt >= W_AMT)) begin
            w_amt_in = i_amt - W_AMT;
        end
    end

    // Arithmetic right runs as a logical right on the operand with its sign bit cleared, so the
    // sticky chain never sees sign copies; the sign fill is ORed back in after the last stage.
    assign w_prep    = (i_mode == MODE_SRA) ? {1'b0, i_din[WIDTH-2:0]} : i_din;
    assign w_sign_in = (i_mode == MODE_SRA) & i_din[WIDTH-1];

    // Shift stages by 2^(SHW-1) down to 1; stages >= 4 see the input beat, stages < 4 the fine beat
    for (genvar k = SHW - 1; k >= 0; k--) begin : g_stage
        localparam int S  = 2 ** k;
        localparam int NL = (S < WIDTH) ? S : WIDTH;
        logic [WIDTH-1:0] src;
        logic             src_st;
        logic             am;
        logic [1:0]       md;
        logic [WIDTH-1:0] sh_l;
        logic [WIDTH-1:0] sh_r;
        logic [WIDTH-1:0] sh_rot;
        logic             right;
        logic [WIDTH-1:0] y;
        logic             y_st;

        if (k == 1) begin : g_src_fine
            assign src    = w_fine_dat;
            assign src_st = w_fine_st;
        end else if (k == SHW - 1) begin : g_src_in
            assign src    = w_prep;
            assign src_st = 1'b0;
        end else begin : g_src_chain
            assign src    = g_stage[k+1].y;
            assign src_st = g_stage[k+1].y_st;
        end

        if (k >= 2) begin : g_ctl_coarse
            assign am = w_amt_in[k];
            assign md = i_mode;
        end else begin : g_ctl_fine
            assign am = w_amt_f[k];
            assign md = w_mode_f;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= S) begin : g_l
                assign sh_l[i] = src[i-S];
            end else begin : g_l0
                assign sh_l[i] = 1'b0;
            end
            if (i + S < WIDTH) begin : g_r
                assign sh_r[i] = src[i+S];
            end else begin : g_r0
                assign sh_r[i] = 1'b0;
            end
            assign sh_rot[i] = src[(i - S + WIDTH) % WIDTH];
        end

        assign right = (md == MODE_SRL) || (md == MODE_SRA);
        assign y     = !am ? src : (md == MODE_SLL) ? sh_l : (md == MODE_ROL) ? sh_rot : sh_r;
        assign y_st  = src_st | (am & right & (|src[NL-1:0]));
    end

    if (SHW > 2) begin : g_coarse_out
        assign w_coarse_dat = g_stage[2].y;
        assign w_coarse_st  = g_stage[2].y_st;
    end else begin : g_coarse_none
        assign w_coarse_dat = w_prep;
        assign w_coarse_st  = 1'b0;
    end

    assign w_out_can = !r_out_vld || i_out_ready;

    if (PIPE_MID != 0) begin : g_mid
        logic             r_mid_vld;
        logic [WIDTH-1:0] r_mid_dat;
        logic             r_mid_st;
        logic [SHW-1:0]   r_mid_amt;
        logic [1:0]       r_mid_mode;
        logic             r_mid_sign;

        // Mid register between coarse and fine stages; takes a beat when empty or advancing
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mid_vld  <= 1'b0;
                r_mid_dat  <= '0;
                r_mid_st   <= 1'b0;
                r_mid_amt  <= '0;
                r_mid_mode <= 2'b00;
                r_mid_sign <= 1'b0;
            end else begin
                if (o_in_ready) begin
                    r_mid_vld <= i_in_valid;
                end
                if (i_in_valid && o_in_ready) begin
                    r_mid_dat  <= w_coarse_dat;
                    r_mid_st   <= w_coarse_st;
                    r_mid_amt  <= w_amt_in;
                    r_mid_mode <= i_mode;
                    r_mid_sign <= w_sign_in;
                end
            end
        end

        assign o_in_ready = !r_mid_vld || w_out_can;
        assign w_fine_vld = r_mid_vld;
        assign w_fine_dat = r_mid_dat;
        assign w_fine_st  = r_mid_st;
        assign w_amt_f    = r_mid_amt;
        assign w_mode_f   = r_mid_mode;
        assign w_sign_f   = r_mid_sign;
    end else begin : g_nomid
        assign o_in_ready = w_out_can;
        assign w_fine_vld = i_in_valid;
        assign w_fine_dat = w_coarse_dat;
        assign w_fine_st  = w_coarse_st;
        assign w_amt_f    = w_amt_in;
        assign w_mode_f   = i_mode;
        assign w_sign_f   = w_sign_in;
    end

    // Sign-fill mask: bit p is a sign copy when p + amt >= WIDTH-1 (all ones once amt >= WIDTH)
    for (genvar p = 0; p < WIDTH; p++) begin : g_fill
        localparam logic [SHW:0] TH = (SHW+1)'(WIDTH - 1 - p);
        assign w_fill[p] = ({1'b0, w_amt_f} >= TH);
    end

    assign w_shifted = g_stage[0].y;
    assign w_sticky  = g_stage[0].y_st;
    assign w_res     = w_shifted | ({WIDTH{w_sign_f}} & w_fill);

    // Output register: result, sticky and zero always move together with the valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_dout    <= '0;
            r_sticky  <= 1'b0;
            r_zero    <= 1'b1;
        end else begin
            if (w_out_can) begin
                r_out_vld <= w_fine_vld;
            end
            if (w_out_can && w_fine_vld) begin
                r_dout   <= w_res;
                r_sticky <= w_sticky;
                r_zero   <= ~|w_res;
            end
        end
    end

    assign o_out_valid = r_out_vld;
    assign o_dout      = r_dout;
    assign o_sticky    = r_sticky;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: drives a PIPE_MID=0 and a PIPE_MID=1 instance with directed and random beats.
// Latency: expected 1 and 2 cycles respectively when the output is not stalled.
// Backpressure: out_ready toggled randomly in the stall phases; results must emerge in order, none lost.
module tb_barrel_shift_pipe;

    typedef struct {
        logic [24:0] din;
        logic [4:0]  amt;
        logic [1:0]  mode;
        bit          lit;
        logic [24:0] ldout;
        bit          lst;
        bit          lzero;
        int          fcyc;
        bit          lchk;
        bit          seen;
    } beat_t;

    localparam int LAT [2] = '{1, 2};

    logic             clk;
    logic             rst_n;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][24:0] din;
    logic [1:0][4:0]  amt;
    logic [1:0][1:0]  mode;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][24:0] dout;
    logic [1:0]       sticky;
    logic [1:0]       zero;

    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    bit    lat_chk = 0;
    int    ofires [2];
    beat_t cur    [2];
    beat_t stim_q [2][$];
    beat_t exp_q  [2][$];

    barrel_shift_pipe #(.WIDTH(25), .SHW(5), .PIPE_MID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_din(din[0]), .i_amt(amt[0]), .i_mode(mode[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
        .o_dout(dout[0]), .o_sticky(sticky[0]), .o_zero(zero[0])
    );

    barrel_shift_pipe #(.WIDTH(25), .SHW(5), .PIPE_MID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_din(din[1]), .i_amt(amt[1]), .i_mode(mode[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
        .o_dout(dout[1]), .o_sticky(sticky[1]), .o_zero(zero[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Reference: plain shift arithmetic on a 64-bit copy of the operand; returns {dout, sticky, zero}
    function automatic logic [26:0] model(input logic [24:0] d, input logic [4:0] a, input logic [1:0] m);
        longint unsigned x, msk, res, lo;
        longint          sx;
        bit              st;
        int              r;
        msk = (64'd1 << 25) - 64'd1;
        x   = {39'd0, d};
        lo  = (64'd1 << a) - 64'd1;
        st  = 1'b0;
        res = 64'd0;
        case (m)
            2'b00: res = (a >= 5'd25) ? 64'd0 : ((x << a) & msk);
            2'b01: begin
                res = (a >= 5'd25) ? 64'd0 : (x >> a);
                st  = (a >= 5'd25) ? (x != 64'd0) : ((x & lo) != 64'd0);
            end
            2'b10: begin
                sx  = $signed({{39{d[24]}}, d});
                res = sx >>> a;
                res = res & msk;
                st  = (a >= 5'd25) ? ((x & ((64'd1 << 24) - 64'd1)) != 64'd0) : ((x & lo) != 64'd0);
            end
            default: begin
                r   = int'(a) % 25;
                res = ((x << r) | (x >> (25 - r))) & msk;
            end
        endcase
        return {res[24:0], st, (res == 64'd0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input logic [24:0] d, input logic [4:0] a, input logic [1:0] m,
                                 input logic [24:0] ld, input bit ls, input bit lz);
        beat_t b;
        b.din = d; b.amt = a; b.mode = m;
        b.lit = 1'b1; b.ldout = ld; b.lst = ls; b.lzero = lz;
        b.fcyc = 0; b.lchk = 1'b0; b.seen = 1'b0;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        logic [4:0] edges [4];
        edges = '{5'd0, 5'd24, 5'd25, 5'd31};
        b = mk(25'($urandom), 5'($urandom), 2'($urandom), 25'd0, 1'b0, 1'b0);
        b.lit = 1'b0;
        if ($urandom_range(0, 3) == 0) b.amt = edges[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) b.din = 25'h1000000 | 25'($urandom_range(0, 3));
        return b;
    endfunction

    task automatic check_out(input int d);
        beat_t       b;
        logic [26:0] e;
        if (out_valid[d]) begin
            if (exp_q[d].size() == 0) begin
                chk($sformatf("stray_beat_d%0d", d), 32'(out_valid[d]), 32'd0);
            end else begin
                b = exp_q[d][0];
                e = model(b.din, b.amt, b.mode);
                chk($sformatf("result_d%0d din=%h amt=%0d mode=%0d", d, b.din, b.amt, b.mode),
                    32'({dout[d], sticky[d], zero[d]}), 32'(e));
                if (b.lit)
                    chk($sformatf("literal_d%0d din=%h amt=%0d mode=%0d", d, b.din, b.amt, b.mode),
                        32'({dout[d], sticky[d], zero[d]}), 32'({b.ldout, b.lst, b.lzero}));
                if (b.lchk && !b.seen)
                    chk($sformatf("latency_d%0d", d), 32'(cyc - b.fcyc), 32'(LAT[d]));
                b.seen = 1'b1;
                exp_q[d][0] = b;
                if (out_ready[d]) begin
                    void'(exp_q[d].pop_front());
                    ofires[d]++;
                end
            end
        end
    endtask

    // One clock: check/record at the falling edge, drive the next inputs just after the rising edge
    task automatic step(input bit rv, input bit rr, input int vpct);
        bit fire [2];
        beat_t b;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            check_out(d);
            fire[d] = in_valid[d] && in_ready[d];
            if (fire[d]) begin
                b = cur[d];
                b.fcyc = cyc; b.lchk = lat_chk; b.seen = 1'b0;
                exp_q[d].push_back(b);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (fire[d] || !in_valid[d]) begin
                if (stim_q[d].size() > 0) begin
                    cur[d] = stim_q[d].pop_front();
                    in_valid[d] = 1'b1;
                end else if (rv && ($urandom_range(1, 100) <= vpct)) begin
                    cur[d] = rand_beat();
                    in_valid[d] = 1'b1;
                end else begin
                    in_valid[d] = 1'b0;
                end
                din[d]  = cur[d].din;
                amt[d]  = cur[d].amt;
                mode[d] = cur[d].mode;
            end
            out_ready[d] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    function automatic bit busy();
        return (in_valid != 2'b00) || (stim_q[0].size() + stim_q[1].size()
               + exp_q[0].size() + exp_q[1].size() != 0);
    endfunction

    task automatic drain(input int budget);
        for (int i = 0; i < budget && busy(); i++) step(1'b0, 1'b0, 0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("drain_left_d%0d", d), 32'(exp_q[d].size() + stim_q[d].size()), 32'd0);
    endtask

    task automatic push_both(input beat_t b);
        stim_q[0].push_back(b);
        stim_q[1].push_back(b);
    endtask

    int base [2];

    initial begin
        rst_n = 1'b0; in_valid = 2'b00; out_ready = 2'b11;
        din = '0; amt = '0; mode = '0;
        ofires = '{0, 0};
        for (int d = 0; d < 2; d++) cur[d] = mk(25'd0, 5'd0, 2'd0, 25'd0, 1'b0, 1'b0);
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid_d%0d", d), 32'(out_valid[d]), 32'd0);
            chk($sformatf("reset_state_d%0d", d), 32'({dout[d], sticky[d], zero[d]}), 32'({25'd0, 1'b0, 1'b1}));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("ready_after_reset_d%0d", d), 32'(in_ready[d]), 32'd1);

        // Directed beats with hand-computed results, output never stalled
        lat_chk = 1'b1;
        push_both(mk(25'h0000001, 5'd24, 2'b00, 25'h1000000, 1'b0, 1'b0));
        push_both(mk(25'h1000000, 5'd4,  2'b10, 25'h1F00000, 1'b0, 1'b0));
        push_both(mk(25'h0000013, 5'd4,  2'b01, 25'h0000001, 1'b1, 1'b0));
        push_both(mk(25'h1FFFFFF, 5'd31, 2'b01, 25'h0000000, 1'b1, 1'b1));
        push_both(mk(25'h1000001, 5'd1,  2'b11, 25'h0000003, 1'b0, 1'b0));
        push_both(mk(25'h1000001, 5'd26, 2'b11, 25'h0000003, 1'b0, 1'b0));
        push_both(mk(25'h1000000, 5'd25, 2'b10, 25'h1FFFFFF, 1'b0, 1'b0));
        push_both(mk(25'h1000001, 5'd30, 2'b10, 25'h1FFFFFF, 1'b1, 1'b0));
        push_both(mk(25'h1FFFFFF, 5'd25, 2'b00, 25'h0000000, 1'b0, 1'b1));
        push_both(mk(25'h0ABCDEF, 5'd25, 2'b11, 25'h0ABCDEF, 1'b0, 1'b0));
        push_both(mk(25'h0ABCDEF, 5'd0,  2'b01, 25'h0ABCDEF, 1'b0, 1'b0));
        push_both(mk(25'h0000001, 5'd31, 2'b11, 25'h0000040, 1'b0, 1'b0));
        drain(60);

        // Back-to-back beats with no stall must move one per cycle
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 100);
        base = ofires;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 100);
        for (int d = 0; d < 2; d++)
            chk($sformatf("throughput_d%0d", d), 32'(ofires[d] - base[d]), 32'd16);
        drain(20);

        // Random traffic with random output stalls
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) step(1'b1, 1'b1, 70);
        drain(60);

        // Reset in the middle of a stalled stream
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 90);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_valid_d%0d", d), 32'(out_valid[d]), 32'd0);
            chk($sformatf("midrst_state_d%0d", d), 32'({dout[d], sticky[d], zero[d]}), 32'({25'd0, 1'b0, 1'b1}));
            exp_q[d].delete();
            stim_q[d].delete();
        end
        in_valid = 2'b00;
        out_ready = 2'b11;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("ready_after_midrst_d%0d", d), 32'(in_ready[d]), 32'd1);

        // First beats after release are processed normally, with nothing stale ahead of them
        lat_chk = 1'b1;
        push_both(mk(25'h0000013, 5'd4, 2'b01, 25'h0000001, 1'b1, 1'b0));
        push_both(mk(25'h1000001, 5'd1, 2'b11, 25'h0000003, 1'b0, 1'b0));
        drain(30);
        lat_chk = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 60);
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
